// File: rtl/axi4_lite_ram.sv
// AXI4-Lite slave backed by a word-organised register array, with independent write and read FSMs.
// Defining AXI4_LITE_RAM_PROT_CHECK_EN answers unprivileged in-range accesses with SLVERR.
module axi4_lite_ram #(
  parameter int ADDR_SIZE = 24,
  parameter int DATA_SIZE = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [ADDR_SIZE-1:0]   awaddr,
  input  logic [2:0]             awprot,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wstrb,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [1:0]             bresp,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [ADDR_SIZE-1:0]   araddr,
  input  logic [2:0]             arprot,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [DATA_SIZE-1:0]   rdata,
  output logic [1:0]             rresp
);

  localparam int STRB_SIZE   = DATA_SIZE / 8;
  localparam int OFFSET_BITS = $clog2(STRB_SIZE);
  localparam int INDEX_BITS  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_SIZE:0] MEM_BYTES = (ADDR_SIZE + 1)'(MEM_DEPTH * STRB_SIZE);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // DECERR outranks SLVERR.
  function automatic logic [1:0] access_resp(input logic in_range, input logic denied);
    if (!in_range) return RESP_DECERR;
    if (denied) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  wstate_t              wstate, wstate_next;
  logic                 aw_hs, w_hs, wr_fire;
  logic [ADDR_SIZE-1:0] aw_addr_q, wr_addr;
  logic [2:0]           aw_prot_q, wr_prot;
  logic [DATA_SIZE-1:0] w_data_q, wr_data;
  logic [STRB_SIZE-1:0] w_strb_q, wr_strb;
  logic [INDEX_BITS-1:0] wr_index;
  logic                 wr_in_range, wr_denied;
  logic [1:0]           wr_resp;
  logic                 awready_next, wready_next, bvalid_next;
  logic [1:0]           bresp_next;

  rstate_t              rstate, rstate_next;
  logic                 ar_hs;
  logic [INDEX_BITS-1:0] rd_index;
  logic                 rd_in_range, rd_denied;
  logic [1:0]           rd_resp;
  logic                 arready_next, rvalid_next;
  logic [DATA_SIZE-1:0] rdata_next;
  logic [1:0]           rresp_next;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // A handshake in the completing cycle bypasses its capture register.
  assign wr_addr = aw_hs ? awaddr : aw_addr_q;
  assign wr_prot = aw_hs ? awprot : aw_prot_q;
  assign wr_data = w_hs ? wdata : w_data_q;
  assign wr_strb = w_hs ? wstrb : w_strb_q;

  assign wr_index    = wr_addr[OFFSET_BITS +: INDEX_BITS];
  assign rd_index    = araddr[OFFSET_BITS +: INDEX_BITS];
  assign wr_in_range = {1'b0, wr_addr} < MEM_BYTES;
  assign rd_in_range = {1'b0, araddr} < MEM_BYTES;

`ifdef AXI4_LITE_RAM_PROT_CHECK_EN
  logic unused_prot;
  assign wr_denied   = !wr_prot[0];
  assign rd_denied   = !arprot[0];
  assign unused_prot = ^{wr_prot[2:1], arprot[2:1]};
`else
  logic unused_prot;
  assign wr_denied   = 1'b0;
  assign rd_denied   = 1'b0;
  assign unused_prot = ^{wr_prot, arprot};
`endif

  assign wr_resp = access_resp(wr_in_range, wr_denied);
  assign rd_resp = access_resp(rd_in_range, rd_denied);
  assign wr_fire = (wstate != W_RESP) && (wstate_next == W_RESP);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wstate    <= W_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      wstate  <= wstate_next;
      awready <= awready_next;
      wready  <= wready_next;
      bvalid  <= bvalid_next;
      bresp   <= bresp_next;
      if (aw_hs) begin
        aw_addr_q <= awaddr;
        aw_prot_q <= awprot;
      end
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  always_comb begin
    wstate_next = wstate;
    case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_next = W_RESP;
        else if (aw_hs)    wstate_next = W_WAIT_W;
        else if (w_hs)     wstate_next = W_WAIT_AW;
      end
      W_WAIT_W:  if (w_hs)   wstate_next = W_RESP;
      W_WAIT_AW: if (aw_hs)  wstate_next = W_RESP;
      W_RESP:    if (bready) wstate_next = W_IDLE;
      default:   wstate_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready_next = (wstate_next == W_IDLE) || (wstate_next == W_WAIT_AW);
    wready_next  = (wstate_next == W_IDLE) || (wstate_next == W_WAIT_W);
    bvalid_next  = (wstate_next == W_RESP);
    bresp_next   = wr_fire ? wr_resp : bresp;
  end

  always_ff @(posedge ACLK) begin
    if (wr_fire && (wr_resp == RESP_OKAY)) begin
      for (int i = 0; i < STRB_SIZE; i++) begin
        if (wr_strb[i]) mem[wr_index][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      rstate  <= rstate_next;
      arready <= arready_next;
      rvalid  <= rvalid_next;
      rdata   <= rdata_next;
      rresp   <= rresp_next;
    end
  end

  always_comb begin
    rstate_next = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs)  rstate_next = R_DATA;
      R_DATA:  if (rready) rstate_next = R_IDLE;
      default: rstate_next = R_IDLE;
    endcase
  end

  // Memory is sampled on the handshake edge, so a same-edge write is not yet visible.
  always_comb begin
    arready_next = (rstate_next == R_IDLE);
    rvalid_next  = (rstate_next == R_DATA);
    rdata_next   = rdata;
    rresp_next   = rresp;
    if (ar_hs) begin
      rresp_next = rd_resp;
      rdata_next = (rd_resp == RESP_OKAY) ? mem[rd_index] : '0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_ram.sv
// Self-checking bench for axi4_lite_ram: directed scenarios plus randomized traffic
// checked against a word-array model of the memory and response rules.
module tb_axi4_lite_ram;

  localparam int MEM_BYTES     = 1024 * 4;
  localparam int PRELOAD_WORDS = 32;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [23:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b1;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [23:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        rvalid, rready = 1'b1;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  always #5 ACLK = ~ACLK;

  axi4_lite_ram dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] model_mem [int];

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [1:0] expect_resp(input logic [23:0] addr);
    return (int'(addr) < MEM_BYTES) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [31:0] model_read(input logic [23:0] addr);
    if (int'(addr) >= MEM_BYTES) return 32'h0;
    return model_mem[int'(addr) / 4];
  endfunction

  task automatic model_write(input logic [23:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] word;
    if (int'(addr) < MEM_BYTES) begin
      word = model_mem.exists(int'(addr) / 4) ? model_mem[int'(addr) / 4] : 32'h0;
      for (int b = 0; b < 4; b++) if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
      model_mem[int'(addr) / 4] = word;
    end
  endtask

  // skew > 0 presents W that many cycles before AW; skew < 0 presents AW first.
  task automatic apply_write(input logic [23:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int skew, input string tag);
    int aw_start, w_start;
    bit aw_done, w_done;
    logic aw_take, w_take;
    aw_start = (skew > 0) ? skew : 0;
    w_start  = (skew < 0) ? -skew : 0;
    aw_done = 1'b0;
    w_done  = 1'b0;
    awaddr = addr;
    awprot = 3'($urandom_range(0, 7));
    wdata  = data;
    wstrb  = strb;
    for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
      awvalid = !aw_done && (c >= aw_start);
      wvalid  = !w_done && (c >= w_start);
      aw_take = awvalid && awready;
      w_take  = wvalid && wready;
      tick();
      aw_done = aw_done || aw_take;
      w_done  = w_done || w_take;
      if (w_done && !aw_done) check_output({tag, "_wready_low"}, 64'(wready), 64'(0));
      if (aw_done && !w_done) check_output({tag, "_awready_low"}, 64'(awready), 64'(0));
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check_output({tag, "_handshake"}, 64'({aw_done, w_done}), 64'(2'b11));
    check_output({tag, "_bvalid"}, 64'(bvalid), 64'(1));
    check_output({tag, "_bresp"}, 64'(bresp), 64'(expect_resp(addr)));
    model_write(addr, data, strb);
    tick();
    check_output({tag, "_idle"}, 64'({bvalid, awready, wready}), 64'(3'b011));
  endtask

  task automatic apply_read(input logic [23:0] addr, input string tag, output logic [31:0] data);
    bit done;
    logic take;
    done = 1'b0;
    araddr = addr;
    arprot = 3'($urandom_range(0, 7));
    for (int c = 0; c < 20 && !done; c++) begin
      arvalid = 1'b1;
      take = arready;
      tick();
      done = take;
    end
    arvalid = 1'b0;
    check_output({tag, "_handshake"}, 64'(done), 64'(1));
    check_output({tag, "_rvalid"}, 64'(rvalid), 64'(1));
    check_output({tag, "_rresp"}, 64'(rresp), 64'(expect_resp(addr)));
    check_output({tag, "_rdata"}, 64'(rdata), 64'(model_read(addr)));
    data = rdata;
    tick();
    check_output({tag, "_idle"}, 64'({rvalid, arready}), 64'(2'b01));
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] old_word;
    logic [23:0] addr;

    #12;
    check_output("reset_readys", 64'({awready, wready, arready}), 64'(0));
    check_output("reset_valids", 64'({bvalid, rvalid}), 64'(0));
    check_output("reset_resps", 64'({bresp, rresp}), 64'(0));
    check_output("reset_rdata", 64'(rdata), 64'(0));
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    check_output("release_before_edge", 64'({awready, wready, arready}), 64'(0));
    tick();
    check_output("release_after_edge", 64'({awready, wready, arready}), 64'(3'b111));

    for (int w = 0; w < PRELOAD_WORDS; w++) apply_write(24'(w * 4), $urandom, 4'hF, 0, "preload");

    apply_write(24'h000010, 32'hDEADBEEF, 4'hF, 0, "t1_wr");
    apply_read(24'h000010, "t1_rd", rd);
    check_output("t1_value", 64'(rd), 64'(32'hDEADBEEF));

    apply_write(24'h000020, 32'hAABBCCDD, 4'hF, 3, "t2_wfirst");
    apply_write(24'h000020, 32'h11223344, 4'b0101, 0, "t2_partial");
    apply_read(24'h000020, "t2_rd", rd);
    check_output("t2_merge", 64'(rd), 64'(32'hAA22CC44));

    apply_write(24'h001000, 32'hCAFEF00D, 4'hF, -2, "t3_oor_wr");
    apply_read(24'h001000, "t3_oor_rd", rd);
    apply_read(24'h000000, "t3_word0", rd);

    bready = 1'b0;
    awaddr = 24'h000030; wdata = 32'h0BADCAFE; wstrb = 4'hF; awprot = 3'b000;
    awvalid = 1'b1; wvalid = 1'b1;
    check_output("stall_w_ready", 64'({awready, wready}), 64'(2'b11));
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(24'h000030, 32'h0BADCAFE, 4'hF);
    for (int i = 0; i < 5; i++) begin
      check_output("stall_b_hold", 64'({bvalid, bresp, awready, wready}), 64'(5'b10000));
      tick();
    end
    bready = 1'b1;
    tick();
    check_output("stall_b_release", 64'({bvalid, awready, wready}), 64'(3'b011));

    rready = 1'b0;
    araddr = 24'h000030; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_output("stall_r_hold", 64'({rvalid, arready, rresp}), 64'(4'b1000));
      check_output("stall_r_data", 64'(rdata), 64'(32'h0BADCAFE));
      tick();
    end
    rready = 1'b1;
    tick();
    check_output("stall_r_release", 64'({rvalid, arready}), 64'(2'b01));

    old_word = model_read(24'h000010);
    awaddr = 24'h000010; wdata = 32'h12345678; wstrb = 4'hF;
    araddr = 24'h000010;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    check_output("same_edge_readys", 64'({awready, wready, arready}), 64'(3'b111));
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_output("same_edge_valids", 64'({bvalid, rvalid}), 64'(2'b11));
    check_output("same_edge_old", 64'(rdata), 64'(old_word));
    check_output("same_edge_deadbeef", 64'(rdata), 64'(32'hDEADBEEF));
    model_write(24'h000010, 32'h12345678, 4'hF);
    tick();
    apply_read(24'h000010, "same_edge_next", rd);
    check_output("same_edge_new", 64'(rd), 64'(32'h12345678));

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) addr = 24'($urandom_range(MEM_BYTES, 24'hFFFFFF));
      else addr = 24'($urandom_range(0, PRELOAD_WORDS - 1) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        apply_write(addr, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3, "rand_wr");
      else
        apply_read(addr, "rand_rd", rd);
    end

    awaddr = 24'h000040; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check_output("mid_wait_w", 64'({awready, wready}), 64'(2'b01));
    #2 ARESETn = 1'b0;
    #1;
    check_output("mid_async_reset", 64'({awready, wready, arready, bvalid, rvalid}), 64'(0));
    tick();
    tick();
    ARESETn = 1'b1;
    check_output("mid_release_pre", 64'({awready, wready, arready}), 64'(0));
    tick();
    check_output("mid_release_post", 64'({awready, wready, arready, bvalid, rvalid}), 64'(5'b11100));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("mid_no_bvalid", 64'(bvalid), 64'(0));
    end
    apply_read(24'h000040, "mid_mem_kept", rd);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
